// File: rtl/crc16_pkg.sv
// Shared CRC-16 constants and frame-checker state encoding.
// Used by the receive checker and the downlink CRC generator.
package crc16_pkg;

  localparam logic [15:0] CRC_POLY   = 16'h8005;
  localparam logic [15:0] CRC_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC_XOROUT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DROP = 2'd2
  } state_t;

endpackage

// File: rtl/crc16_next.sv
// Combinational one-byte CRC-16 update, MSB first, non-reflected.
// Zero latency; no flow control.
module crc16_next
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLYNOMIAL = CRC_POLY
) (
  input  logic [15:0] crc,
  input  logic [7:0]  data,
  output logic [15:0] crc_nxt
);

  always_comb begin
    crc_nxt = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      crc_nxt = crc_nxt[15] ? ((crc_nxt << 1) ^ POLYNOMIAL) : (crc_nxt << 1);
    end
  end

endmodule

// File: rtl/crc16_frame_check.sv
// Receive CRC-16 frame checker: strips the two trailing CRC bytes, reports status per frame.
// Payload byte appears 1 cycle after the second-following byte is accepted; status 1 cycle after eof; no backpressure.
module crc16_frame_check
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLYNOMIAL = CRC_POLY,
  parameter logic [15:0] INIT_VALUE = CRC_INIT,
  parameter logic [15:0] MAX_LEN    = 16'd1024
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  input  logic        sof_in,
  input  logic        eof_in,
  output logic [7:0]  data_out,
  output logic        data_out_valid,
  output logic        data_out_sof,
  output logic        data_out_last,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        len_err,
  output logic        frame_abort,
  output logic [15:0] payload_len,
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt
);

  state_t      state, state_nxt;
  logic [7:0]  dl0, dl1;
  logic [15:0] tot, rel_cnt, crc_reg, crc_upd, fin_plen;
  logic        pend_len;
  logic        sof_acc, mid, rel, ovf, crc_match, fin_len_err, ok_inc, err_inc;

  // dl1 is always the byte due for release, so the CRC folds it in as it leaves.
  crc16_next #(.POLYNOMIAL(POLYNOMIAL)) u_crc_next (
    .crc     (crc_reg),
    .data    (dl1),
    .crc_nxt (crc_upd)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    sof_acc     = valid_in && sof_in;
    mid         = valid_in && !sof_in && (state != IDLE);
    rel         = mid && (state == RUN) && (tot >= 16'd2) && (rel_cnt != MAX_LEN);
    ovf         = mid && (state == RUN) && (tot >= 16'd2) && (rel_cnt == MAX_LEN);
    crc_match   = ((crc_upd ^ CRC_XOROUT) == {dl0, data_in});
    fin_len_err = (state == DROP) || (tot < 16'd2) || ovf;
    fin_plen    = (tot >= 16'd2) ? (tot - 16'd1) : 16'd0;
    ok_inc      = mid && eof_in && !fin_len_err && crc_match;
    err_inc     = pend_len || (sof_acc && ((state != IDLE) || eof_in)) ||
                  (mid && eof_in && (fin_len_err || !crc_match));
    case (state)
      IDLE: begin
        if (sof_acc && !eof_in) state_nxt = RUN;
      end
      RUN, DROP: begin
        if (sof_acc)             state_nxt = eof_in ? IDLE : RUN;
        else if (mid && eof_in)  state_nxt = IDLE;
        else if (ovf)            state_nxt = DROP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      dl0            <= '0;
      dl1            <= '0;
      tot            <= '0;
      rel_cnt        <= '0;
      crc_reg        <= INIT_VALUE;
      pend_len       <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      data_out_sof   <= 1'b0;
      data_out_last  <= 1'b0;
      frame_done     <= 1'b0;
      crc_ok         <= 1'b0;
      crc_err        <= 1'b0;
      len_err        <= 1'b0;
      frame_abort    <= 1'b0;
      payload_len    <= '0;
    end else begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
      data_out_sof   <= 1'b0;
      data_out_last  <= 1'b0;
      frame_done     <= 1'b0;
      crc_ok         <= 1'b0;
      crc_err        <= 1'b0;
      len_err        <= 1'b0;
      frame_abort    <= 1'b0;
      payload_len    <= '0;
      pend_len       <= 1'b0;
      // A 1-byte frame that also aborted the previous one reports one cycle after the abort.
      if (pend_len) begin
        frame_done <= 1'b1;
        len_err    <= 1'b1;
      end
      if (rel) begin
        data_out       <= dl1;
        data_out_valid <= 1'b1;
        data_out_sof   <= (rel_cnt == 16'd0);
        data_out_last  <= eof_in;
        rel_cnt        <= rel_cnt + 16'd1;
        crc_reg        <= crc_upd;
      end
      if (sof_acc) begin
        dl0     <= data_in;
        dl1     <= '0;
        tot     <= 16'd1;
        rel_cnt <= '0;
        crc_reg <= INIT_VALUE;
        if (state != IDLE) begin
          frame_done  <= 1'b1;
          frame_abort <= 1'b1;
          pend_len    <= eof_in;
        end else if (eof_in) begin
          frame_done <= 1'b1;
          len_err    <= 1'b1;
        end
      end else if (mid) begin
        dl1 <= dl0;
        dl0 <= data_in;
        if (tot != 16'hFFFF) tot <= tot + 16'd1;
        if (eof_in) begin
          frame_done  <= 1'b1;
          crc_ok      <= !fin_len_err && crc_match;
          crc_err     <= !fin_len_err && !crc_match;
          len_err     <= fin_len_err;
          payload_len <= fin_plen;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (ok_inc && (ok_cnt != 16'hFFFF))   ok_cnt  <= ok_cnt + 16'd1;
      if (err_inc && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_crc16_frame_check.sv
// Bench for crc16_frame_check: directed and random frames on a default and a MAX_LEN=4 instance,
// compared against a queue-based frame model with a bit-serial reference CRC.
module tb_crc16_frame_check;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data_in = '0;
  logic        valid_in = 1'b0;
  logic        sof_in = 1'b0;
  logic        eof_in = 1'b0;

  logic [7:0]  d_out [2];
  logic        d_vld [2];
  logic        d_sof [2];
  logic        d_last [2];
  logic        fdone [2];
  logic        s_ok [2];
  logic        s_err [2];
  logic        s_len [2];
  logic        s_abt [2];
  logic [15:0] plen [2];
  logic [15:0] okc [2];
  logic [15:0] errc [2];

  always #5 clk_in = ~clk_in;

  crc16_frame_check dut (
    .clk_in(clk_in), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .sof_in(sof_in), .eof_in(eof_in),
    .data_out(d_out[0]), .data_out_valid(d_vld[0]), .data_out_sof(d_sof[0]),
    .data_out_last(d_last[0]), .frame_done(fdone[0]), .crc_ok(s_ok[0]),
    .crc_err(s_err[0]), .len_err(s_len[0]), .frame_abort(s_abt[0]),
    .payload_len(plen[0]), .ok_cnt(okc[0]), .err_cnt(errc[0])
  );

  crc16_frame_check #(.MAX_LEN(16'd4)) dut_small (
    .clk_in(clk_in), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .sof_in(sof_in), .eof_in(eof_in),
    .data_out(d_out[1]), .data_out_valid(d_vld[1]), .data_out_sof(d_sof[1]),
    .data_out_last(d_last[1]), .frame_done(fdone[1]), .crc_ok(s_ok[1]),
    .crc_err(s_err[1]), .len_err(s_len[1]), .frame_abort(s_abt[1]),
    .payload_len(plen[1]), .ok_cnt(okc[1]), .err_cnt(errc[1])
  );

  // Observed traffic: data words {sof,last,byte}, status words {last_same,abort,len,err,ok,plen}.
  logic [9:0]  got_d0 [$];
  logic [9:0]  got_d1 [$];
  logic [20:0] got_s0 [$];
  logic [20:0] got_s1 [$];
  int          idle_bad = 0;

  always @(negedge clk_in) begin
    for (int i = 0; i < 2; i++) begin
      if (d_vld[i]) begin
        if (i == 0) got_d0.push_back({d_sof[i], d_last[i], d_out[i]});
        else        got_d1.push_back({d_sof[i], d_last[i], d_out[i]});
      end else if (d_out[i] != 8'h00 || d_sof[i] || d_last[i]) begin
        idle_bad++;
      end
      if (fdone[i]) begin
        if (i == 0) got_s0.push_back({d_last[i] & d_vld[i], s_abt[i], s_len[i], s_err[i], s_ok[i], plen[i]});
        else        got_s1.push_back({d_last[i] & d_vld[i], s_abt[i], s_len[i], s_err[i], s_ok[i], plen[i]});
      end else if (s_abt[i] || s_len[i] || s_err[i] || s_ok[i] || plen[i] != 16'h0) begin
        idle_bad++;
      end
    end
  end

  // Expected traffic produced by the model.
  logic [9:0]  exp_d0 [$];
  logic [9:0]  exp_d1 [$];
  logic [20:0] exp_s0 [$];
  logic [20:0] exp_s1 [$];
  int          exp_ok [2];
  int          exp_err [2];
  int          bd [2];
  int          bs [2];
  logic [7:0]  frm [$];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_crc(input int n);
    logic [15:0] r = 16'hFFFF;
    logic        fb;
    for (int k = 0; k < n; k++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = r[15] ^ frm[k][b];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h8005;
      end
    end
    return r ^ 16'hFFFF;
  endfunction

  task automatic model(input int i, input int ml, input bit aborted);
    int          n = frm.size();
    int          p = (n >= 2) ? n - 2 : 0;
    int          rel = 0;
    bit          normal = 0;
    bit          good = 0;
    logic [15:0] p16 = p[15:0];
    logic [20:0] st;
    if (aborted) begin
      rel = (p > ml) ? ml : p;
      st  = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    end else if (n < 3) begin
      st  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    end else if (p > ml) begin
      rel = ml;
      st  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, p16};
    end else begin
      rel    = p;
      normal = 1;
      good   = (ref_crc(p) == {frm[n-2], frm[n-1]});
      st     = {1'b1, 1'b0, 1'b0, !good, good, p16};
    end
    for (int k = 0; k < rel; k++) begin
      if (i == 0) exp_d0.push_back({k == 0, normal && (k == rel - 1), frm[k]});
      else        exp_d1.push_back({k == 0, normal && (k == rel - 1), frm[k]});
    end
    if (i == 0) exp_s0.push_back(st);
    else        exp_s1.push_back(st);
    if (good) exp_ok[i]++;
    else      exp_err[i]++;
  endtask

  task automatic model2(input bit aborted);
    model(0, 1024, aborted);
    model(1, 4, aborted);
  endtask

  task automatic put(input logic [7:0] b, input logic s, input logic e, input int gmax);
    int g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
    valid_in = 1'b0;
    repeat (g) begin @(posedge clk_in); #1; end
    valid_in = 1'b1; data_in = b; sof_in = s; eof_in = e;
    @(posedge clk_in); #1;
    valid_in = 1'b0; data_in = '0; sof_in = 1'b0; eof_in = 1'b0;
  endtask

  task automatic send(input int gmax, input bit with_eof);
    for (int k = 0; k < frm.size(); k++)
      put(frm[k], k == 0, with_eof && (k == frm.size() - 1), gmax);
  endtask

  function automatic int dsz(input int i);
    return (i == 0) ? got_d0.size() : got_d1.size();
  endfunction
  function automatic int ssz(input int i);
    return (i == 0) ? got_s0.size() : got_s1.size();
  endfunction

  task automatic check_all(input string tag);
    int nd, ns, ed, es;
    repeat (4) @(posedge clk_in);
    #1;
    for (int i = 0; i < 2; i++) begin
      nd = dsz(i) - bd[i];
      ns = ssz(i) - bs[i];
      ed = (i == 0) ? exp_d0.size() : exp_d1.size();
      es = (i == 0) ? exp_s0.size() : exp_s1.size();
      chk($sformatf("%s/u%0d/nbytes", tag, i), nd, ed);
      for (int k = 0; k < nd && k < ed; k++)
        chk($sformatf("%s/u%0d/byte%0d", tag, i, k),
            (i == 0) ? got_d0[bd[i] + k] : got_d1[bd[i] + k],
            (i == 0) ? exp_d0[k] : exp_d1[k]);
      chk($sformatf("%s/u%0d/nstatus", tag, i), ns, es);
      for (int k = 0; k < ns && k < es; k++)
        chk($sformatf("%s/u%0d/status%0d", tag, i, k),
            (i == 0) ? got_s0[bs[i] + k] : got_s1[bs[i] + k],
            (i == 0) ? exp_s0[k] : exp_s1[k]);
      chk($sformatf("%s/u%0d/ok_cnt", tag, i), okc[i], exp_ok[i]);
      chk($sformatf("%s/u%0d/err_cnt", tag, i), errc[i], exp_err[i]);
      bd[i] = dsz(i);
      bs[i] = ssz(i);
    end
    exp_d0.delete(); exp_d1.delete(); exp_s0.delete(); exp_s1.delete();
  endtask

  task automatic req023_frame();
    frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h51, 8'h18};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      exp_ok[i] = 0; exp_err[i] = 0; bd[i] = 0; bs[i] = 0;
    end
    repeat (3) @(posedge clk_in);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset/u%0d/valid", i), d_vld[i], 1'b0);
      chk($sformatf("reset/u%0d/data", i), d_out[i], 8'h00);
      chk($sformatf("reset/u%0d/done", i), fdone[i], 1'b0);
      chk($sformatf("reset/u%0d/ok_cnt", i), okc[i], 16'h0);
      chk($sformatf("reset/u%0d/err_cnt", i), errc[i], 16'h0);
    end
    rst_n = 1'b1;
    @(posedge clk_in); #1;

    req023_frame();
    send(0, 1); model2(0); check_all("good_frame");

    req023_frame();
    frm[10] = 8'h19;
    send(3, 1); model2(0); check_all("crc_err_gaps");

    frm = '{8'h00, 8'h00};
    send(1, 1); model2(0); check_all("two_byte");

    frm.delete();
    for (int k = 0; k < 9; k++) frm.push_back(8'($urandom));
    send(0, 1); model2(0); check_all("overflow");

    frm.delete();
    for (int k = 0; k < 5; k++) frm.push_back(8'($urandom));
    send(1, 0); model2(1);
    req023_frame();
    send(0, 1); model2(0); check_all("abort_then_good");

    frm = '{8'h11, 8'h22, 8'h33, 8'h44};
    send(0, 0); model2(1);
    frm = '{8'hA5};
    put(8'hA5, 1'b1, 1'b1, 0); model2(0); check_all("abort_sof_eof");

    for (int k = 0; k < 4; k++) put(8'($urandom), 1'b0, 1'($urandom), 1);
    check_all("idle_stray");

    frm = '{8'h01, 8'h02, 8'h03, 8'h04};
    send(0, 0);
    rst_n = 1'b0;
    @(posedge clk_in); #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("midreset/u%0d/ok_cnt", i), okc[i], 16'h0);
      chk($sformatf("midreset/u%0d/err_cnt", i), errc[i], 16'h0);
      exp_ok[i] = 0; exp_err[i] = 0;
      bd[i] = dsz(i); bs[i] = ssz(i);
    end
    rst_n = 1'b1;
    @(posedge clk_in); #1;
    req023_frame();
    send(2, 1); model2(0); check_all("after_reset");

    for (int r = 0; r < 8; r++) begin
      logic [15:0] c;
      n = int'($urandom_range(12, 1));
      frm.delete();
      for (int k = 0; k < n; k++) frm.push_back(8'($urandom));
      if (n >= 3) begin
        c = ref_crc(n - 2);
        frm[n-2] = c[15:8];
        frm[n-1] = c[7:0];
        if ($urandom_range(2, 0) == 0) frm[$urandom_range(n - 1, 0)] ^= 8'(1 << $urandom_range(7, 0));
      end
      send(int'($urandom_range(2, 0)), 1); model2(0);
      check_all($sformatf("random%0d", r));
    end

    chk("idle_outputs_low", idle_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
